// File: rtl/nfu_3_act.sv
// nfu_3_act: NFU-3 activation stage.
// Applies a shared, programmable 16-segment piecewise-linear activation
// y = a[seg]*x + b[seg] to G parallel Q8.8 neuron sums through a 2-deep
// valid/ready pipeline (stage 1: segment lookup, stage 2: multiply-add-saturate).
// Optional feature macro: NFU3_RELU_EN adds i_relu, a per-beat ReLU bypass.
module nfu_3_act #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int G         = 4,
  parameter int SEG_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [G*BIT_WIDTH-1:0] i_nfu2,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [G*BIT_WIDTH-1:0] o_act,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic                   i_cfg_we,
  input  logic [SEG_BITS-1:0]    i_cfg_addr,
  input  logic [BIT_WIDTH-1:0]   i_cfg_a,
  input  logic [BIT_WIDTH-1:0]   i_cfg_b
`ifdef NFU3_RELU_EN
  ,
  input  logic                   i_relu
`endif
);

  localparam int W        = BIT_WIDTH;
  localparam int NSEG     = 1 << SEG_BITS;
  localparam int IP_W     = W - FRAC_BITS;
  localparam int SEG_HALF = NSEG / 2;

  // Integer-part bounds that map onto the first and last segment.
  localparam logic signed [IP_W-1:0]   IP_MIN   = IP_W'(-SEG_HALF);
  localparam logic signed [IP_W-1:0]   IP_MAX   = IP_W'(SEG_HALF - 1);
  // Adding SEG_HALF to an in-range integer part is a flip of the segment MSB.
  localparam logic [SEG_BITS-1:0]      SEG_FLIP = SEG_BITS'(SEG_HALF);

  // Coefficient table (needs reset-to-zero, so it lives in flops)
  logic [W-1:0] a_tbl_reg [NSEG];
  logic [W-1:0] b_tbl_reg [NSEG];

  // Pipeline state
  logic           s1_valid_reg;
  logic [G*W-1:0] s1_x_reg;
  logic [G*W-1:0] s1_a_reg;
  logic [G*W-1:0] s1_b_reg;
  logic [G*W-1:0] s1_a_next;
  logic [G*W-1:0] s1_b_next;
  logic [G*W-1:0] act_next;
  logic           o_valid_reg;
  logic [G*W-1:0] o_act_reg;
`ifdef NFU3_RELU_EN
  logic           s1_relu_reg;
`endif

  logic adv1;
  logic adv2;

  // Stage 2 may advance when empty or draining; stage 1 when empty or stage 2 advances.
  assign adv2    = !o_valid_reg || i_ready;
  assign adv1    = !s1_valid_reg || adv2;
  assign o_ready = adv1;
  assign o_valid = o_valid_reg;
  assign o_act   = o_act_reg;

  // Table write port; a write becomes visible to lookups in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        a_tbl_reg[i] <= '0;
        b_tbl_reg[i] <= '0;
      end
    end else if (i_cfg_we) begin
      a_tbl_reg[i_cfg_addr] <= i_cfg_a;
      b_tbl_reg[i_cfg_addr] <= i_cfg_b;
    end
  end

  for (genvar gi = 0; gi < G; gi++) begin : g_lane
    // ---- stage 1: segment select and coefficient lookup ----
    logic signed [IP_W-1:0]    ip;
    logic [SEG_BITS-1:0]       seg;

    assign ip = i_nfu2[gi*W+FRAC_BITS +: IP_W];

    // Clamp floor(x) into the segment range and bias it to a table index.
    always_comb begin
      seg = ip[SEG_BITS-1:0] ^ SEG_FLIP;
      if (ip < IP_MIN) begin
        seg = '0;
      end else if (ip > IP_MAX) begin
        seg = '1;
      end
    end

    assign s1_a_next[gi*W +: W] = a_tbl_reg[seg];
    assign s1_b_next[gi*W +: W] = b_tbl_reg[seg];

    // ---- stage 2: multiply, shift, add offset, saturate ----
    logic signed [W-1:0]   x_l;
    logic signed [W-1:0]   b_l;
    logic signed [2*W-1:0] x_e;
    logic signed [2*W-1:0] a_e;
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_sh;
    logic [2*W:0]          sum;
    logic [W-1:0]          pwl_y;
    logic [W-1:0]          lane_y;
    logic [W+1:0]          sum_hi;

    assign x_l     = s1_x_reg[gi*W +: W];
    assign b_l     = s1_b_reg[gi*W +: W];
    assign x_e     = {{W{x_l[W-1]}}, x_l};
    assign a_e     = {{W{s1_a_reg[gi*W+W-1]}}, s1_a_reg[gi*W +: W]};
    assign prod    = a_e * x_e;
    // Arithmetic shift truncates toward -inf; no rounding term.
    assign prod_sh = prod >>> FRAC_BITS;
    assign sum     = {prod_sh[2*W-1], prod_sh} + {{(W+1){b_l[W-1]}}, b_l};
    assign sum_hi  = sum[2*W:W-1];

    // Saturate: the sum fits in W bits only if its top bits are all sign copies.
    always_comb begin
      pwl_y = sum[W-1:0];
      if (!((sum_hi == '0) || (sum_hi == '1))) begin
        pwl_y = sum[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
    end

`ifdef NFU3_RELU_EN
    assign lane_y = s1_relu_reg ? (x_l[W-1] ? '0 : x_l) : pwl_y;
`else
    assign lane_y = pwl_y;
`endif

    assign act_next[gi*W +: W] = lane_y;
  end

  // Stage 1 register: capture the beat together with its coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
`ifdef NFU3_RELU_EN
      s1_relu_reg  <= 1'b0;
`endif
    end else if (adv1) begin
      s1_valid_reg <= i_valid;
      s1_x_reg     <= i_nfu2;
      s1_a_reg     <= s1_a_next;
      s1_b_reg     <= s1_b_next;
`ifdef NFU3_RELU_EN
      s1_relu_reg  <= i_relu;
`endif
    end
  end

  // Output register: holds steady while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_reg <= 1'b0;
      o_act_reg   <= '0;
    end else if (adv2) begin
      o_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        o_act_reg <= act_next;
      end
    end
  end

endmodule

// File: tb/tb_nfu_3_act.sv
// Testbench for nfu_3_act (G=4, Q8.8). Scoreboard of expected beats, pushed
// on input transfer and popped on output transfer.
module tb_nfu_3_act;

  logic        clk;
  logic        rst_n;
  logic [63:0] i_nfu2;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] o_act;
  logic        o_valid;
  logic        i_ready;
  logic        i_cfg_we;
  logic [3:0]  i_cfg_addr;
  logic [15:0] i_cfg_a;
  logic [15:0] i_cfg_b;
`ifdef NFU3_RELU_EN
  logic        i_relu;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_a [16];
  int m_b [16];
  logic [63:0] exp_q [$];

  nfu_3_act dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_nfu2     (i_nfu2),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_act      (o_act),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_addr (i_cfg_addr),
    .i_cfg_a    (i_cfg_a),
    .i_cfg_b    (i_cfg_b)
`ifdef NFU3_RELU_EN
    ,
    .i_relu     (i_relu)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: floor division by 256 instead of shifts, wide integers, explicit clamps.
  function automatic logic [63:0] model(input logic [63:0] x, input logic relu);
    logic [63:0] r;
    int          xi, ip, seg;
    longint      p, q, s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      xi = int'($signed(x[k*16 +: 16]));
      if (relu) begin
        s = (xi < 0) ? 0 : xi;
      end else begin
        ip = (xi >= 0) ? xi / 256 : -((-xi + 255) / 256);
        if (ip < -8) ip = -8;
        if (ip > 7)  ip = 7;
        seg = ip + 8;
        p = longint'(m_a[seg]) * longint'(xi);
        q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        s = q + longint'(m_b[seg]);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
      end
      r[k*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] beat_x(input int n);
    return {16'(n + 48), 16'(n + 32), 16'(n + 16), 16'(n)};
  endfunction

  task automatic cfg_write(input logic [3:0] addr, input logic [15:0] a, input logic [15:0] b);
    i_cfg_we = 1'b1; i_cfg_addr = addr; i_cfg_a = a; i_cfg_b = b;
    @(posedge clk); #1;
    i_cfg_we = 1'b0;
    m_a[addr] = int'($signed(a));
    m_b[addr] = int'($signed(b));
  endtask

  task automatic cfg_all(input logic [15:0] a, input logic [15:0] b);
    for (int s = 0; s < 16; s++) cfg_write(4'(s), a, b);
  endtask

  // Drive one beat until accepted; push its expected result.
  task automatic drive_beat(input logic [63:0] x, input logic relu, output logic accepted);
    i_nfu2 = x; i_valid = 1'b1;
`ifdef NFU3_RELU_EN
    i_relu = relu;
`endif
    accepted = 1'b0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (o_ready) begin
        accepted = 1'b1;
        exp_q.push_back(model(x, relu));
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  // Wait (bounded) for the next output transfer; report the cycles it took.
  task automatic collect(output logic [63:0] act, output logic got, output int cycles);
    got = 1'b0; act = '0; cycles = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      cycles++;
      if (o_valid && i_ready) begin
        act = o_act; got = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
    n_checks++; if (o_act !== 64'h0) begin n_fail++; $display("FAIL reset_o_act got=%h want=0", o_act); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready got=%b want=1", o_ready); end
    $display("reset: o_valid=%b o_act=%h o_ready=%b", o_valid, o_act, o_ready);
  endtask

  // Single beat through the PWL path, checked against model and a spec literal.
  task automatic one_beat(input string name, input logic [63:0] x, input logic relu,
                          input logic [63:0] lit, input logic check_lat);
    logic [63:0] act, e;
    logic acc, got;
    int cyc;
    drive_beat(x, relu, acc);
    collect(act, got, cyc);
    n_checks++;
    if (!acc || !got || exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s_handshake accepted=%b got=%b want both 1", name, acc, got);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin n_fail++; $display("FAIL %s_model got=%h want=%h", name, act, e); end
      n_checks++;
      if (act !== lit) begin n_fail++; $display("FAIL %s_literal got=%h want=%h", name, act, lit); end
      if (check_lat) begin
        n_checks++;
        if (cyc !== 2) begin n_fail++; $display("FAIL %s_latency got=%0d want=2", name, cyc); end
      end
    end
    $display("%s: x=%h act=%h", name, x, act);
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    cfg_all(16'h0040, 16'h0080);
    one_beat("basic", {4{16'h0100}}, 1'b0, {4{16'h00C0}}, 1'b1);
  endtask

  task automatic test_seg_clamp();
    cfg_write(4'd0, 16'h0000, 16'h0111);
    cfg_write(4'd15, 16'h0000, 16'h0222);
    one_beat("seg_clamp", {16'h7FFF, 16'h0700, 16'hF800, 16'h8000}, 1'b0,
             {16'h0222, 16'h0222, 16'h0111, 16'h0111}, 1'b0);
  endtask

  task automatic test_saturation();
    cfg_all(16'h7FFF, 16'h7FFF);
    one_beat("sat_pos", {4{16'h7FFF}}, 1'b0, {4{16'h7FFF}}, 1'b0);
    cfg_all(16'h7FFF, 16'h8000);
    one_beat("sat_neg", {4{16'h8000}}, 1'b0, {4{16'h8000}}, 1'b0);
  endtask

  // Config write in the same cycle as an accepted beat must not affect that beat.
  task automatic test_cfg_timing();
    logic [63:0] act, e;
    logic got;
    int cyc;
    cfg_all(16'h0000, 16'h0010);
    i_ready = 1'b1;
    i_cfg_we = 1'b1; i_cfg_addr = 4'd8; i_cfg_a = 16'h0000; i_cfg_b = 16'h0020;
    i_nfu2 = {4{16'h0050}}; i_valid = 1'b1;
`ifdef NFU3_RELU_EN
    i_relu = 1'b0;
`endif
    @(negedge clk);
    if (o_ready) exp_q.push_back(model(i_nfu2, 1'b0));
    @(posedge clk); #1;
    i_cfg_we = 1'b0; m_b[8] = 32'h20;
    i_nfu2 = {4{16'h0060}};
    @(negedge clk);
    if (o_ready) exp_q.push_back(model(i_nfu2, 1'b0));
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      collect(act, got, cyc);
      n_checks++;
      if (!got || exp_q.size() == 0) begin
        n_fail++; $display("FAIL cfg_timing_%0d no output got=%b", n, got);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin n_fail++; $display("FAIL cfg_timing_%0d got=%h want=%h", n, act, e); end
      end
      $display("cfg_timing beat %0d: act=%h", n, act);
    end
  endtask

  // Stream 8 beats with a repeating i_ready pattern (bit c%4 for cycle c).
  task automatic test_stream(input string name, input logic [3:0] pat);
    logic [63:0] e;
    int sent, recv, inflight;
    logic in_x, out_x, want_rdy;
    sent = 0; recv = 0;
    cfg_all(16'h0100, 16'h0000);
    i_ready = pat[0]; i_nfu2 = beat_x(1); i_valid = 1'b1;
`ifdef NFU3_RELU_EN
    i_relu = 1'b0;
`endif
    for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
      @(negedge clk);
      inflight = sent - recv;
      want_rdy = !(inflight == 2 && !i_ready);
      n_checks++;
      if (o_ready !== want_rdy) begin
        n_fail++; $display("FAIL %s_o_ready cyc=%0d got=%b want=%b", name, cyc, o_ready, want_rdy);
      end
      out_x = o_valid && i_ready;
      in_x  = i_valid && o_ready;
      if (out_x) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s_extra_output act=%h want=none", name, o_act);
        end else begin
          e = exp_q.pop_front();
          if (o_act !== e) begin n_fail++; $display("FAIL %s_beat%0d got=%h want=%h", name, recv, o_act, e); end
        end
        $display("%s: out beat %0d act=%h", name, recv, o_act);
        recv++;
      end
      if (in_x) begin
        exp_q.push_back(model(i_nfu2, 1'b0));
        sent++;
      end
      @(posedge clk); #1;
      i_nfu2  = beat_x(sent + 1);
      i_valid = (sent < 8);
      i_ready = pat[(cyc + 1) % 4];
    end
    i_valid = 1'b0; i_ready = 1'b1;
    n_checks++;
    if (recv !== 8 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL %s_count got=%0d left=%0d want=8 left=0", name, recv, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    cfg_all(16'h0100, 16'h0000);
    i_ready = 1'b1;
    i_nfu2 = {4{16'h0200}}; i_valid = 1'b1;
`ifdef NFU3_RELU_EN
    i_relu = 1'b0;
`endif
    @(posedge clk); #1;
    i_nfu2 = {4{16'h0300}};
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inflight got=%b want=1", o_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_o_valid got=%b want=0", o_valid); end
    n_checks++; if (o_act !== 64'h0) begin n_fail++; $display("FAIL rst_mid_o_act got=%h want=0", o_act); end
    $display("reset_mid: o_valid=%b o_act=%h", o_valid, o_act);
    exp_q.delete();
    for (int s = 0; s < 16; s++) begin m_a[s] = 0; m_b[s] = 0; end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    acc = 1'b0;
    one_beat("after_reset", {4{16'h0100}}, 1'b0, 64'h0, 1'b1);
  endtask

`ifdef NFU3_RELU_EN
  task automatic test_relu();
    cfg_all(16'h0040, 16'h0080);
    one_beat("relu_on", {16'h8000, 16'h0000, 16'h0300, 16'hFF00}, 1'b1,
             {16'h0000, 16'h0000, 16'h0300, 16'h0000}, 1'b1);
    one_beat("relu_off", {4{16'h0100}}, 1'b0, {4{16'h00C0}}, 1'b1);
  endtask
`endif

  initial begin
    for (int s = 0; s < 16; s++) begin m_a[s] = 0; m_b[s] = 0; end
    i_nfu2 = '0; i_valid = 1'b0; i_ready = 1'b1;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_a = '0; i_cfg_b = '0;
`ifdef NFU3_RELU_EN
    i_relu = 1'b0;
`endif
    test_reset();
    test_basic();
    test_seg_clamp();
    test_saturation();
    test_cfg_timing();
    test_stream("back_to_back", 4'b1111);
    test_stream("backpressure", 4'b1001);
    test_reset_mid();
`ifdef NFU3_RELU_EN
    test_relu();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
